// File: rtl/broadcast_unit_pkg.sv
// Shared types and constants for the result broadcast unit.
// A result entry packs a destination tag with its 32-bit value.
package broadcast_unit_pkg;

  localparam int PREG_W    = 6;
  localparam int NUM_PREG  = 64;
  localparam int DATA_W    = 32;
  localparam int DEPTH_DEF = 4;

  typedef struct packed {
    logic [PREG_W-1:0] map;
    logic [DATA_W-1:0] val;
  } result_t;

  typedef enum logic {
    SRC_EXE = 1'b0,
    SRC_MEM = 1'b1
  } src_e;

  // Tag 0 is the hardwired "no destination" register.
  function automatic logic tag_live(input logic [PREG_W-1:0] tag);
    return tag != '0;
  endfunction

endpackage

// File: rtl/broadcast_unit_if.sv
// Result offers from exe/mem, rename allocation, and the wakeup/regfile/busy
// outputs of the broadcast unit.
interface broadcast_unit_if;
  import broadcast_unit_pkg::*;

  logic                alloc_valid;
  logic [PREG_W-1:0]   alloc_map;
  logic                exe_valid;
  logic [PREG_W-1:0]   exe_map;
  logic [DATA_W-1:0]   exe_val;
  logic                exe_ready;
  logic                mem_valid;
  logic [PREG_W-1:0]   mem_map;
  logic [DATA_W-1:0]   mem_val;
  logic                mem_ready;
  logic                exe_broadcast;
  logic [PREG_W-1:0]   exe_broadcast_map;
  logic [DATA_W-1:0]   exe_broadcast_val;
  logic                mem_broadcast;
  logic [PREG_W-1:0]   mem_broadcast_map;
  logic [DATA_W-1:0]   mem_broadcast_val;
  logic                preg_we;
  logic [PREG_W-1:0]   preg_waddr;
  logic [DATA_W-1:0]   preg_wdata;
  logic [NUM_PREG-1:0] busy;

  modport master (
    output alloc_valid, alloc_map,
    output exe_valid, exe_map, exe_val,
    output mem_valid, mem_map, mem_val,
    input  exe_ready, mem_ready,
    input  exe_broadcast, exe_broadcast_map, exe_broadcast_val,
    input  mem_broadcast, mem_broadcast_map, mem_broadcast_val,
    input  preg_we, preg_waddr, preg_wdata, busy
  );

  modport slave (
    input  alloc_valid, alloc_map,
    input  exe_valid, exe_map, exe_val,
    input  mem_valid, mem_map, mem_val,
    output exe_ready, mem_ready,
    output exe_broadcast, exe_broadcast_map, exe_broadcast_val,
    output mem_broadcast, mem_broadcast_map, mem_broadcast_val,
    output preg_we, preg_waddr, preg_wdata, busy
  );

endinterface

// File: rtl/broadcast_unit_result_fifo.sv
// Per-source result FIFO; pushes while full are refused, never overwrite.
module result_fifo
  import broadcast_unit_pkg::*;
#(
  parameter int DEPTH = DEPTH_DEF
) (
  input  logic    CLK,
  input  logic    RESET,
  input  logic    flush_i,
  input  logic    push_i,
  input  logic    pop_i,
  input  result_t din_i,
  output logic    full_o,
  output logic    empty_o,
  output result_t head_o
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);

  result_t        mem_q [DEPTH];
  logic [PW-1:0]  wr_q, wr_d, rd_q, rd_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic           do_push, do_pop;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  assign full_o  = (cnt_q == CW'(DEPTH));
  assign empty_o = (cnt_q == '0);
  assign head_o  = mem_q[rd_q];
  assign do_push = push_i & ~full_o;
  assign do_pop  = pop_i & ~empty_o;

  always_comb begin
    wr_d  = do_push ? ptr_inc(wr_q) : wr_q;
    rd_d  = do_pop  ? ptr_inc(rd_q) : rd_q;
    cnt_d = cnt_q + CW'(do_push) - CW'(do_pop);
  end

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else if (flush_i) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      wr_q  <= wr_d;
      rd_q  <= rd_d;
      cnt_q <= cnt_d;
    end
  end

  always_ff @(posedge CLK) begin
    if (do_push && !flush_i) mem_q[wr_q] <= din_i;
  end

endmodule

// File: rtl/broadcast_unit.sv
// Merges exe and mem results onto one regfile write port with registered
// wakeup broadcasts, round-robin arbitration and a per-tag busy scoreboard.
module broadcast_unit
  import broadcast_unit_pkg::*;
#(
  parameter int DEPTH  = DEPTH_DEF,
  parameter int PREG_W = broadcast_unit_pkg::PREG_W
) (
  input  logic             CLK,
  input  logic             RESET,
  input  logic             FLUSH,
  broadcast_unit_if.slave  bus
);

  localparam int NTAG = 2 ** PREG_W;

  result_t          exe_head, mem_head, exe_din, mem_din;
  logic             exe_full, exe_empty, mem_full, mem_empty;
  logic             exe_push, mem_push, gnt_exe, gnt_mem, contend;
  src_e             rr_q, rr_d;
  logic [NTAG-1:0]  busy_q, busy_d;
  logic             exe_bc_q, exe_bc_d, mem_bc_q, mem_bc_d, preg_we_q, preg_we_d;
  result_t          exe_res_q, exe_res_d, mem_res_q, mem_res_d, preg_q, preg_d;

  // Map-0 offers are handshaken normally but never enqueued.
  assign exe_push = bus.exe_valid & ~exe_full & tag_live(bus.exe_map);
  assign mem_push = bus.mem_valid & ~mem_full & tag_live(bus.mem_map);
  assign exe_din  = '{map: bus.exe_map, val: bus.exe_val};
  assign mem_din  = '{map: bus.mem_map, val: bus.mem_val};

  result_fifo #(.DEPTH(DEPTH)) u_exe_fifo (
    .CLK(CLK), .RESET(RESET), .flush_i(FLUSH), .push_i(exe_push), .pop_i(gnt_exe),
    .din_i(exe_din), .full_o(exe_full), .empty_o(exe_empty), .head_o(exe_head)
  );

  result_fifo #(.DEPTH(DEPTH)) u_mem_fifo (
    .CLK(CLK), .RESET(RESET), .flush_i(FLUSH), .push_i(mem_push), .pop_i(gnt_mem),
    .din_i(mem_din), .full_o(mem_full), .empty_o(mem_empty), .head_o(mem_head)
  );

  always_comb begin
    contend   = ~exe_empty & ~mem_empty;
    gnt_exe   = ~exe_empty & (mem_empty | (rr_q == SRC_EXE));
    gnt_mem   = ~mem_empty & ~gnt_exe;
    rr_d      = rr_q;
    exe_bc_d  = 1'b0;
    exe_res_d = '0;
    mem_bc_d  = 1'b0;
    mem_res_d = '0;
    preg_we_d = 1'b0;
    preg_d    = '0;
    if (contend) rr_d = (rr_q == SRC_EXE) ? SRC_MEM : SRC_EXE;
    if (gnt_exe) begin
      exe_bc_d  = 1'b1;
      exe_res_d = exe_head;
      preg_we_d = 1'b1;
      preg_d    = exe_head;
    end else if (gnt_mem) begin
      mem_bc_d  = 1'b1;
      mem_res_d = mem_head;
      preg_we_d = 1'b1;
      preg_d    = mem_head;
    end
    // Clear before set so a same-edge allocation of the retiring tag wins.
    busy_d = busy_q;
    if (preg_we_d) busy_d[preg_d.map] = 1'b0;
    if (bus.alloc_valid) busy_d[bus.alloc_map] = 1'b1;
    busy_d[0] = 1'b0;
  end

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      rr_q      <= SRC_EXE;
      busy_q    <= '0;
      exe_bc_q  <= 1'b0;
      exe_res_q <= '0;
      mem_bc_q  <= 1'b0;
      mem_res_q <= '0;
      preg_we_q <= 1'b0;
      preg_q    <= '0;
    end else if (FLUSH) begin
      rr_q      <= SRC_EXE;
      busy_q    <= '0;
      exe_bc_q  <= 1'b0;
      exe_res_q <= '0;
      mem_bc_q  <= 1'b0;
      mem_res_q <= '0;
      preg_we_q <= 1'b0;
      preg_q    <= '0;
    end else begin
      rr_q      <= rr_d;
      busy_q    <= busy_d;
      exe_bc_q  <= exe_bc_d;
      exe_res_q <= exe_res_d;
      mem_bc_q  <= mem_bc_d;
      mem_res_q <= mem_res_d;
      preg_we_q <= preg_we_d;
      preg_q    <= preg_d;
    end
  end

  assign bus.exe_ready         = ~exe_full;
  assign bus.mem_ready         = ~mem_full;
  assign bus.exe_broadcast     = exe_bc_q;
  assign bus.exe_broadcast_map = exe_res_q.map;
  assign bus.exe_broadcast_val = exe_res_q.val;
  assign bus.mem_broadcast     = mem_bc_q;
  assign bus.mem_broadcast_map = mem_res_q.map;
  assign bus.mem_broadcast_val = mem_res_q.val;
  assign bus.preg_we           = preg_we_q;
  assign bus.preg_waddr        = preg_q.map;
  assign bus.preg_wdata        = preg_q.val;
  assign bus.busy              = busy_q;

endmodule

// File: tb/tb_broadcast_unit.sv
// Randomised and directed bench for broadcast_unit against a queue-based
// reference model of the two result streams and the busy scoreboard.
module tb_broadcast_unit;
  import broadcast_unit_pkg::*;

  localparam int D = 4;

  logic CLK = 1'b0;
  logic RESET = 1'b0;
  logic FLUSH = 1'b0;

  broadcast_unit_if bus();

  broadcast_unit #(.DEPTH(D)) dut (
    .CLK(CLK), .RESET(RESET), .FLUSH(FLUSH), .bus(bus)
  );

  always #5 CLK = ~CLK;

  int n_chk = 0;
  int n_pass = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0h want %0h", tag, obs, exp);
  endtask

  // Reference model: plain queues of {map,val}, a priority bit, a busy word.
  logic [37:0] q_e[$];
  logic [37:0] q_m[$];
  bit          pri_mem;
  logic [63:0] m_busy;
  logic        x_ebc, x_mbc, x_we;
  logic [5:0]  x_emap, x_mmap, x_wa;
  logic [31:0] x_eval, x_mval, x_wd;
  bit          last_e_acc, last_m_acc;

  task automatic model_clear();
    q_e.delete();
    q_m.delete();
    pri_mem = 0;
    m_busy = '0;
    {x_ebc, x_mbc, x_we} = '0;
    {x_emap, x_mmap, x_wa} = '0;
    {x_eval, x_mval, x_wd} = '0;
  endtask

  task automatic drive_idle();
    bus.alloc_valid = 0; bus.alloc_map = '0;
    bus.exe_valid = 0; bus.exe_map = '0; bus.exe_val = '0;
    bus.mem_valid = 0; bus.mem_map = '0; bus.mem_val = '0;
    FLUSH = 0;
  endtask

  task automatic check_outputs();
    chk("exe_broadcast", bus.exe_broadcast, x_ebc);
    chk("exe_bc_map", bus.exe_broadcast_map, x_emap);
    chk("exe_bc_val", bus.exe_broadcast_val, x_eval);
    chk("mem_broadcast", bus.mem_broadcast, x_mbc);
    chk("mem_bc_map", bus.mem_broadcast_map, x_mmap);
    chk("mem_bc_val", bus.mem_broadcast_val, x_mval);
    chk("preg_we", bus.preg_we, x_we);
    chk("preg_waddr", bus.preg_waddr, x_wa);
    chk("preg_wdata", bus.preg_wdata, x_wd);
    chk("busy", bus.busy, m_busy);
  endtask

  task automatic cyc(input bit av, input int am, input bit ev, input int em,
                     input logic [31:0] ed, input bit mv, input int mm,
                     input logic [31:0] md, input bit fl);
    int g;
    logic [37:0] h;
    @(negedge CLK);
    bus.alloc_valid = av; bus.alloc_map = 6'(am);
    bus.exe_valid = ev; bus.exe_map = 6'(em); bus.exe_val = ed;
    bus.mem_valid = mv; bus.mem_map = 6'(mm); bus.mem_val = md;
    FLUSH = fl;
    #1;
    chk("exe_ready", bus.exe_ready, q_e.size() < D);
    chk("mem_ready", bus.mem_ready, q_m.size() < D);
    last_e_acc = ev && (q_e.size() < D);
    last_m_acc = mv && (q_m.size() < D);
    @(posedge CLK);
    {x_ebc, x_mbc, x_we} = '0;
    {x_emap, x_mmap, x_wa} = '0;
    {x_eval, x_mval, x_wd} = '0;
    if (fl) begin
      model_clear();
    end else begin
      g = -1;
      if (q_e.size() > 0 && (q_m.size() == 0 || !pri_mem)) g = 0;
      else if (q_m.size() > 0) g = 1;
      if (q_e.size() > 0 && q_m.size() > 0) pri_mem = !pri_mem;
      if (g == 0) begin
        h = q_e.pop_front();
        x_ebc = 1; x_emap = h[37:32]; x_eval = h[31:0];
      end else if (g == 1) begin
        h = q_m.pop_front();
        x_mbc = 1; x_mmap = h[37:32]; x_mval = h[31:0];
      end
      if (g >= 0) begin
        x_we = 1; x_wa = h[37:32]; x_wd = h[31:0];
        m_busy[h[37:32]] = 1'b0;
      end
      if (last_e_acc && em != 0) q_e.push_back({6'(em), ed});
      if (last_m_acc && mm != 0) q_m.push_back({6'(mm), md});
      if (av && am != 0) m_busy[am] = 1'b1;
    end
    #1;
    check_outputs();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic async_reset();
    @(negedge CLK);
    #2;
    RESET = 0;
    drive_idle();
    model_clear();
    #1;
    chk("rst_busy", bus.busy, 64'd0);
    chk("rst_exe_bc", bus.exe_broadcast, 1'b0);
    chk("rst_mem_bc", bus.mem_broadcast, 1'b0);
    chk("rst_preg_we", bus.preg_we, 1'b0);
    chk("rst_exe_ready", bus.exe_ready, 1'b1);
    chk("rst_mem_ready", bus.mem_ready, 1'b1);
    @(negedge CLK);
    RESET = 1;
  endtask

  initial begin
    int k, j, tries;
    drive_idle();
    model_clear();
    #3;
    chk("por_busy", bus.busy, 64'd0);
    chk("por_preg_we", bus.preg_we, 1'b0);
    chk("por_exe_ready", bus.exe_ready, 1'b1);
    chk("por_mem_ready", bus.mem_ready, 1'b1);
    @(negedge CLK);
    RESET = 1;

    // Single exe result with busy tag.
    cyc(1, 5, 0, 0, 0, 0, 0, 0, 0);
    cyc(0, 0, 1, 5, 32'hDEADBEEF, 0, 0, 0, 0);
    idle(1);
    chk("d31_bc", bus.exe_broadcast, 1'b1);
    chk("d31_map", bus.exe_broadcast_map, 6'd5);
    chk("d31_val", bus.exe_broadcast_val, 32'hDEADBEEF);
    chk("d31_waddr", bus.preg_waddr, 6'd5);
    chk("d31_busy5", bus.busy[5], 1'b0);

    // Contention then round-robin.
    cyc(0, 0, 1, 3, 32'h33, 1, 9, 32'h99, 0);
    idle(1);
    chk("d32_exe_first", bus.exe_broadcast_map, 6'd3);
    idle(1);
    chk("d32_mem_second", bus.mem_broadcast_map, 6'd9);
    cyc(0, 0, 1, 11, 32'h1111, 1, 12, 32'h1212, 0);
    idle(1);
    chk("d32_rr_mem", bus.mem_broadcast, 1'b1);
    idle(2);

    // Back-to-back mem offers with exe competing; retry until accepted.
    k = 0; j = 0; tries = 0;
    while (k < 5 && tries < 40) begin
      cyc(0, 0, 1, 40 + (j % 8), 32'hE000 + j, 1, 50 + k, 32'hA000 + k, 0);
      if (last_m_acc) k++;
      if (last_e_acc) j++;
      tries++;
    end
    chk("d33_all_accepted", k, 5);
    idle(12);

    // Allocation of a tag on the edge it retires keeps it busy.
    cyc(1, 7, 0, 0, 0, 0, 0, 0, 0);
    cyc(0, 0, 1, 7, 32'h77, 0, 0, 0, 0);
    cyc(1, 7, 0, 0, 0, 0, 0, 0, 0);
    chk("d34_waddr", bus.preg_waddr, 6'd7);
    chk("d34_busy7", bus.busy[7], 1'b1);

    // Tag-0 offers are dropped.
    cyc(0, 0, 1, 0, 32'h1234, 1, 0, 32'h1234, 0);
    idle(1);
    chk("d35_no_we", bus.preg_we, 1'b0);

    // Flush with queued entries.
    cyc(1, 20, 1, 20, 32'h20, 1, 21, 32'h21, 0);
    cyc(1, 22, 1, 22, 32'h22, 1, 23, 32'h23, 0);
    cyc(0, 0, 1, 24, 32'h24, 1, 25, 32'h25, 1);
    chk("d36_flush_busy", bus.busy, 64'd0);
    chk("d36_flush_we", bus.preg_we, 1'b0);
    idle(2);

    // Asynchronous reset with queued entries.
    cyc(1, 30, 1, 30, 32'h30, 1, 31, 32'h31, 0);
    cyc(1, 32, 1, 32, 32'h32, 1, 33, 32'h33, 0);
    async_reset();
    idle(3);

    // Random traffic.
    for (int i = 0; i < 400; i++) begin
      if (i == 200) async_reset();
      cyc($urandom_range(0, 3) != 0, $urandom_range(0, 63),
          $urandom_range(0, 9) < 8, $urandom_range(0, 63), $urandom,
          $urandom_range(0, 9) < 8, $urandom_range(0, 63), $urandom,
          $urandom_range(0, 39) == 0);
    end
    idle(10);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/broadcast_unit.md
BROADCAST_UNIT -- requirements
Module: broadcast_unit

Interface
REQ-001 Parameter DEPTH, default 4: entries per source result FIFO.
REQ-002 Parameter PREG_W, default 6: physical-register tag width, 64 tags.
REQ-003 CLK  input  1  clock; all state updates on rising edge.
REQ-004 RESET  input  1  reset, asynchronous, active-low.
REQ-005 FLUSH  input  1  synchronous pipeline flush.
REQ-006 alloc_valid / alloc_map  input  1 / 6  rename allocates a destination tag; marks it busy.
REQ-007 exe_valid / exe_map / exe_val  input  1 / 6 / 32  execution result offer.
REQ-008 exe_ready  output  1  exe FIFO not full; transfer when exe_valid & exe_ready.
REQ-009 mem_valid / mem_map / mem_val / mem_ready  in / in / in / out  1 / 6 / 32 / 1  memory-stage result offer, same handshake.
REQ-010 exe_broadcast / exe_broadcast_map / exe_broadcast_val  output  1 / 6 / 32  wakeup to issue queue, exe channel.
REQ-011 mem_broadcast / mem_broadcast_map / mem_broadcast_val  output  1 / 6 / 32  wakeup to issue queue, mem channel.
REQ-012 preg_we / preg_waddr / preg_wdata  output  1 / 6 / 32  single physical-register-file write port.
REQ-013 busy  output  64  per-tag busy vector read by rename and issue.

Function
REQ-014 Offers with map 0 are accepted (ready honoured) but discarded: no enqueue, no broadcast, no write.
REQ-015 Each source has its own DEPTH-entry FIFO; ready = not full, evaluated before the same-edge pop.
REQ-016 Push and pop on the same edge are legal when full only if ready was already high; full FIFO deasserts ready, no overwrite.
REQ-017 Per cycle exactly one FIFO head is granted; grant pops the head, drives preg write and that source's broadcast, all registered.
REQ-018 Latency: a result accepted at edge N into an empty FIFO with no contention appears on outputs after edge N+1.
REQ-019 Arbitration: only one non-empty -> grant it; both non-empty -> round-robin pointer; pointer flips to the other source after every contended grant; pointer resets to exe.
REQ-020 Non-granted broadcast channel drives valid 0, map 0, val 0; preg_we 0 when no grant.
REQ-021 busy[t] is set at the edge alloc_valid with alloc_map = t (t != 0); cleared at the edge a grant for tag t is registered.
REQ-022 Same-edge alloc and clear of the same tag: set wins.
REQ-023 busy[0] is constantly 0.
REQ-024 FIFO pointers and counts wrap modulo DEPTH; count width holds 0..DEPTH.
REQ-025 FLUSH: empties both FIFOs, zeroes busy and all registered outputs, resets pointer to exe; inputs offered that cycle are dropped; FLUSH overrides alloc.

Reset
REQ-026 RESET low, asynchronous: FIFOs empty, busy = 0, all broadcast/preg outputs 0, arbitration pointer = exe.
REQ-027 Ready outputs are 1 out of reset (combinational from empty FIFOs).
REQ-028 Reset asserted mid-transfer discards all pending results; no partial broadcast after release.

Structure
REQ-029 Shared package holds PREG_W, NUM_PREG = 64, DEPTH default, and the result-entry packing (map + val, 38 bits).
REQ-030 One sub-module, result_fifo, instantiated twice (exe, mem): push/pop/full/empty/head, parameterised by DEPTH.

Verification
REQ-031 exe offer map 5 val 0xDEADBEEF alone, busy[5]=1 -> next cycle exe_broadcast=1 map 5 val 0xDEADBEEF, preg_we=1 addr 5, busy[5]=0.
REQ-032 exe map 3 and mem map 9 on the same edge -> exe broadcasts cycle 1, mem cycle 2; the next contention grants mem first.
REQ-033 mem offers every cycle while exe holds priority, 5 offers -> mem_ready low after 4 queued; no loss; all 5 later broadcast in order.
REQ-034 alloc_map 7 on the same edge as a grant for tag 7 -> busy[7] remains 1.
REQ-035 Offer map 0 val 0x1234 -> ready high, no broadcast, preg_we stays 0.
REQ-036 3 entries queued, FLUSH pulsed -> next cycle FIFOs empty, busy = 0, no broadcasts; same with RESET low mid-queue asynchronously.
